// File: rtl/dac_play_sched.sv
// dac_play_sched: playback scheduler for the I2S DAC serializer.
// Fetches one 16-bit sample per stereo frame from sample memory, paced by
// the falling edge of daclrc. Applies speed control (skip in fast mode,
// repeat in slow mode), play/pause/stop, and drives the serializer's
// data/data_en sample input.
module dac_play_sched #(
   parameter int ADDR_W      = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              daclrc,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [3:0]        speed,
   input  logic [ADDR_W-1:0] end_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       data,
   output logic              data_en,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_FETCH
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [SYNC_STAGES-1:0] lrc_sync;
   logic                   lrc_hist;
   logic                   frame_tick;

   // One extra address bit so that stepping past end_addr can never wrap
   // back into the valid range.
   logic [ADDR_W:0] addr;
   logic [ADDR_W:0] addr_step;
   logic [ADDR_W:0] addr_nxt;
   logic            past_end;

   logic [2:0]  factor;
   logic [2:0]  rep_cnt;
   logic [2:0]  rep_load;
   logic [15:0] sample_q;

   // Bring daclrc into the clk domain and keep one cycle of history for
   // edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lrc_sync <= '0;
         lrc_hist <= 1'b0;
      end else begin
         lrc_sync <= {lrc_sync[SYNC_STAGES-2:0], daclrc};
         lrc_hist <= lrc_sync[SYNC_STAGES-1];
      end
   end

   // A left frame starts when the synchronized LR clock falls.
   assign frame_tick = lrc_hist & ~lrc_sync[SYNC_STAGES-1];

   // A speed factor of zero behaves like normal speed.
   assign factor = (speed[2:0] == 3'd0) ? 3'd1 : speed[2:0];

   // Slow mode walks every address; fast mode skips ahead by the factor.
   assign addr_step = speed[3] ? {{ADDR_W{1'b0}}, 1'b1}
                               : {{(ADDR_W-2){1'b0}}, factor};
   assign addr_nxt  = addr + addr_step;
   assign past_end  = addr > {1'b0, end_addr};

   // Extra plays of each fetched sample in slow mode; a one-sample clip is
   // played exactly once regardless of the factor.
   assign rep_load = (speed[3] && (end_addr != '0)) ? (factor - 3'd1) : 3'd0;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection: stop beats start, start beats frame/ack events.
   always_comb begin
      state_nxt = state;
      if (stop) begin
         state_nxt = S_IDLE;
      end else if (start) begin
         state_nxt = S_WAIT;
      end else begin
         case (state)
            S_WAIT: begin
               if (frame_tick && !pause && (rep_cnt == 3'd0)) begin
                  state_nxt = past_end ? S_IDLE : S_FETCH;
               end
            end
            S_FETCH: begin
               if (mem_ack) begin
                  state_nxt = S_WAIT;
               end
            end
            default: begin
               state_nxt = state;
            end
         endcase
      end
   end

   // Status output decoded from the state.
   always_comb begin
      busy = (state != S_IDLE);
   end

   // Playback datapath: address, repeat count, memory request and the
   // registered sample interface. Repeats replay the last fetched sample,
   // so silence inserted by pause never leaks into a repeat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr     <= '0;
         rep_cnt  <= 3'd0;
         sample_q <= 16'h0000;
         data     <= 16'h0000;
         data_en  <= 1'b0;
         done     <= 1'b0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         underrun <= 1'b0;
      end else begin
         data_en <= 1'b0;
         done    <= 1'b0;
         if (stop) begin
            mem_req <= 1'b0;
         end else if (start) begin
            mem_req  <= 1'b0;
            addr     <= '0;
            rep_cnt  <= 3'd0;
            underrun <= 1'b0;
         end else begin
            case (state)
               S_WAIT: begin
                  if (frame_tick) begin
                     if (pause) begin
                        data    <= 16'h0000;
                        data_en <= 1'b1;
                     end else if (rep_cnt != 3'd0) begin
                        data    <= sample_q;
                        data_en <= 1'b1;
                        rep_cnt <= rep_cnt - 3'd1;
                     end else if (past_end) begin
                        done <= 1'b1;
                     end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= addr[ADDR_W-1:0];
                     end
                  end
               end
               S_FETCH: begin
                  if (frame_tick) begin
                     underrun <= 1'b1;
                  end
                  if (mem_ack) begin
                     data     <= mem_rdata;
                     sample_q <= mem_rdata;
                     data_en  <= 1'b1;
                     mem_req  <= 1'b0;
                     addr     <= addr_nxt;
                     rep_cnt  <= rep_load;
                  end
               end
               default: begin
                  mem_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
